det_hessian: RTL
================

// Module: det_hessian
// PURPOSE
//  Downstream join stage of the derXX/derYY/derXY box-filter pipeline. Aligns the three
//  Hessian second-derivative streams and computes the normalised SURF response
//  det(H) = (Dxx*Dyy - WEIGHT*Dxy^2) >>> NORM_SHIFT, saturated to OUT_WIDTH.
//  The result feeds the scale-space extremum stage over a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH   28   width of each derivative input, signed two's complement
//  OUT_WIDTH    32   width of det output, signed two's complement
//  WEIGHT       207  Dxy^2 weight in Q0.8 format (207/256 ~ 0.9^2)
//  NORM_SHIFT   12   arithmetic right shift applied before saturation (area normalisation)
//  FIFO_DEPTH   4    alignment FIFO depth per channel; must be a power of 2
// PORTS
//  clk            in   1           system clock
//  rst_n          in   1           synchronous active-low reset
//  Dxx_d_i        in   DATA_WIDTH  Dxx sample
//  Dxx_d_i_valid  in   1           Dxx valid; may be stretched over multiple cycles
//  Dyy_d_i        in   DATA_WIDTH  Dyy sample
//  Dyy_d_i_valid  in   1           Dyy valid; may be stretched over multiple cycles
//  Dxy_d_i        in   DATA_WIDTH  Dxy sample
//  Dxy_d_i_valid  in   1           Dxy valid; may be stretched over multiple cycles
//  det_o          out  OUT_WIDTH   normalised determinant
//  det_o_valid    out  1           det_o holds a result
//  det_o_ready    in   1           downstream accepts det_o
//  ovf_err        out  1           sticky flag: a sample was dropped on a full FIFO
// BEHAVIOUR
//  - Reset: synchronous, active-low (rst_n==0 at posedge clk).
//    Reset empties all FIFOs, clears the pipeline valids and the edge-detect registers,
//    and drives det_o=0, det_o_valid=0, ovf_err=0.
//    Reset mid-operation discards all in-flight samples.
//  - Capture: each channel registers its previous valid.
//    A sample is captured only on a rising edge (valid=1, prev=0), using the data present
//    in that cycle. Upstream holds valid for two cycles; one sample is taken per pulse.
//  - Channel FIFO: each channel has its own FIFO of depth FIFO_DEPTH.
//    A rising edge while the FIFO is full drops the sample and sets ovf_err (sticky
//    until reset). Pointers wrap modulo FIFO_DEPTH. A capture and a pop in the same
//    cycle on a full FIFO is accepted, with no drop.
//  - Join: advance = !det_o_valid | det_o_ready.
//    The three FIFOs pop together when advance=1 and all three are non-empty.
//    A partial set is never consumed.
//  - Pipeline: four stages, all enabled by advance. Valid bits travel alongside the data.
//    S1 registers the popped Dxx, Dyy, Dxy.
//    S2 computes P = Dxx*Dyy and Q = Dxy*Dxy, each 2*DATA_WIDTH signed.
//    S3 computes R = (Q*WEIGHT) >>> 8, keeping the full width, and delays P by one stage.
//    S4 computes D = (P - R) >>> NORM_SHIFT at 2*DATA_WIDTH+1 bits.
//    D saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and is registered into det_o.
//  - Latency: 4 clk from the join pop to det_o_valid with no stall. Throughput is 1 result/clk.
//  - Handshake: det_o and det_o_valid hold stable while det_o_valid=1 and det_o_ready=0.
//    The whole pipeline freezes in that case; bubbles are not compressed.
//    A transfer occurs when det_o_valid & det_o_ready are both high.
//  - Ordering: results leave in arrival order. The n-th Dxx, n-th Dyy and n-th Dxy
//    always pair together.
// TESTING
//  1. Dxx=100, Dyy=200, Dxy=0, all valids as 2-cycle pulses in the same cycle,
//     ready=1 -> one det_o = 20000>>>12 = 4, det_o_valid high for 1 cycle,
//     4 clk after the pop.
//  2. Dxy arrives 3 clk after Dxx/Dyy; Dxx=Dyy=4096, Dxy=4096 ->
//     det_o = (2^24 - (2^24*207>>>8))>>>12 = 784, emitted only after Dxy arrives.
//  3. Dxx=2^27-1, Dyy=2^27-1, Dxy=0 -> det_o=2^31-1 (saturated).
//     Dxx=2^27-1, Dyy=-2^27, Dxy=0 -> det_o=-2^31.
//  4. Stream 6 samples on Dxx/Dyy only, with no Dxy, then 6 Dxy samples ->
//     ovf_err=1 after the 5th Dxx pulse. Exactly 4 results are produced, in order.
//  5. det_o_ready=0 for 10 clk during a burst of 3 -> det_o holds its first value with
//     no loss. Release ready -> 3 results come out on consecutive cycles in order.
//  6. Assert rst_n=0 for 1 clk with 2 samples in flight ->
//     det_o_valid=0, ovf_err=0, FIFOs empty. The next aligned triple gives a correct
//     result with a 4-clk latency.

Source files
------------

// File: rtl/det_hessian.sv
// det_hessian: joins the Dxx/Dyy/Dxy derivative streams through per-channel
// alignment FIFOs and computes the saturated, normalised Hessian determinant
// (Dxx*Dyy - WEIGHT*Dxy^2) >>> NORM_SHIFT over a valid/ready output.
module det_hessian #(
   parameter int DATA_WIDTH = 28,
   parameter int OUT_WIDTH  = 32,
   parameter int WEIGHT     = 207,
   parameter int NORM_SHIFT = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] Dxx_d_i,
   input  logic                  Dxx_d_i_valid,
   input  logic [DATA_WIDTH-1:0] Dyy_d_i,
   input  logic                  Dyy_d_i_valid,
   input  logic [DATA_WIDTH-1:0] Dxy_d_i,
   input  logic                  Dxy_d_i_valid,
   output logic [OUT_WIDTH-1:0]  det_o,
   output logic                  det_o_valid,
   input  logic                  det_o_ready,
   output logic                  ovf_err
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int DW = 2 * DATA_WIDTH + 1;
   localparam int QW = PW + 10;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic signed [9:0]    WEIGHT_S = 10'(WEIGHT);
   localparam logic signed [DW-1:0] SAT_MAX  = {{(DW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [DW-1:0] SAT_MIN  = {{(DW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   logic                  advance;
   logic                  pop;
   logic [2:0]            in_valid;
   logic [2:0]            empty;
   logic [2:0]            drop;
   logic [DATA_WIDTH-1:0] in_data [3];
   logic [DATA_WIDTH-1:0] head    [3];

   assign in_valid = {Dxy_d_i_valid, Dyy_d_i_valid, Dxx_d_i_valid};
   assign in_data[0] = Dxx_d_i;
   assign in_data[1] = Dyy_d_i;
   assign in_data[2] = Dxy_d_i;

   // A frozen output stalls everything; the join only fires with a complete triple.
   assign advance = !det_o_valid || det_o_ready;
   assign pop     = advance && (empty == 3'b000);

   for (genvar ch = 0; ch < 3; ch++) begin : g_chan
      logic                  prev_valid;
      logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
      logic [AW-1:0]         wr_ptr;
      logic [AW-1:0]         rd_ptr;
      logic [CW-1:0]         count;
      logic                  capture;
      logic                  is_full;
      logic                  accept;

      assign capture  = in_valid[ch] && !prev_valid;
      assign is_full  = (count == CW'(FIFO_DEPTH));
      assign accept   = capture && (!is_full || pop);
      assign empty[ch] = (count == '0);
      assign drop[ch]  = capture && is_full && !pop;
      assign head[ch]  = mem[rd_ptr];

      // Rising-edge capture into the channel FIFO; a simultaneous pop frees the slot.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            prev_valid <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
         end else begin
            prev_valid <= in_valid[ch];
            if (accept) begin
               mem[wr_ptr] <= in_data[ch];
               wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

   logic signed [DATA_WIDTH-1:0] s1_xx, s1_yy, s1_xy;
   logic                         s1_valid;
   logic signed [PW-1:0]         s2_p, s2_q;
   logic                         s2_valid;
   logic signed [PW-1:0]         s3_p;
   logic signed [DW-1:0]         s3_r;
   logic                         s3_valid;

   logic signed [PW-1:0] prod_p, prod_q;
   logic signed [QW-1:0] q_weighted;
   logic signed [DW-1:0] diff, d_shift;
   logic [OUT_WIDTH-1:0] sat_val;

   // Datapath arithmetic for each stage, evaluated from the current stage registers.
   always_comb begin
      prod_p     = PW'(s1_xx) * PW'(s1_yy);
      prod_q     = PW'(s1_xy) * PW'(s1_xy);
      q_weighted = QW'(s2_q) * QW'(WEIGHT_S);
      diff       = DW'(s3_p) - s3_r;
      d_shift    = diff >>> NORM_SHIFT;
      sat_val    = d_shift[OUT_WIDTH-1:0];
      if (d_shift > SAT_MAX) begin
         sat_val = SAT_MAX[OUT_WIDTH-1:0];
      end else if (d_shift < SAT_MIN) begin
         sat_val = SAT_MIN[OUT_WIDTH-1:0];
      end
   end

   // Four-stage pipeline moving in lockstep; valids travel with the data and bubbles stay put.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid    <= 1'b0;
         s1_xx       <= '0;
         s1_yy       <= '0;
         s1_xy       <= '0;
         s2_valid    <= 1'b0;
         s2_p        <= '0;
         s2_q        <= '0;
         s3_valid    <= 1'b0;
         s3_p        <= '0;
         s3_r        <= '0;
         det_o_valid <= 1'b0;
         det_o       <= '0;
      end else if (advance) begin
         s1_valid    <= pop;
         s1_xx       <= head[0];
         s1_yy       <= head[1];
         s1_xy       <= head[2];
         s2_valid    <= s1_valid;
         s2_p        <= prod_p;
         s2_q        <= prod_q;
         s3_valid    <= s2_valid;
         s3_p        <= s2_p;
         s3_r        <= DW'(q_weighted >>> 8);
         det_o_valid <= s3_valid;
         det_o       <= sat_val;
      end
   end

   // Sticky record of any sample lost to a full FIFO.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_err <= 1'b0;
      end else if (drop != 3'b000) begin
         ovf_err <= 1'b1;
      end
   end

endmodule
